i2s_transmitter: RTL
====================

Name: i2s_transmitter

Overview:
Serialises stereo PCM samples onto the DECA audio codec's I2S pins: mclk, bclk, wclk and sdout (the codec's DIN input).
It sits in DECA_soc between the audio sample source (CPU-written registers or DMA) and the top-level audio pins.
It accepts left/right sample pairs through a valid/ready handshake into a small FIFO.
It emits one stereo frame of 64 bclk periods continuously while enabled, in standard I2S (Philips) format.

Parameters:
SAMPLE_WIDTH, 16, bits per channel sample; must be between 1 and 32.
MCLK_DIV, 4, clk cycles per mclk period; must be even and at least 2.
BCLK_DIV, 16, clk cycles per bclk period; must be even and at least 4. At a 50 MHz clk this gives a frame rate of about 48.8 kHz.
FIFO_DEPTH, 2, number of stereo pair entries; must be a power of 2.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous reset, active-low.
enable  in  1  run the bclk/wclk/sdout serialiser.
sampleValid  in  1  a sample pair is offered.
sampleReady  out  1  the FIFO can accept a pair.
sampleLeft  in  SAMPLE_WIDTH  left channel sample, two's complement.
sampleRight  in  SAMPLE_WIDTH  right channel sample, two's complement.
underflowClear  in  1  clears the sticky underflow flag.
underflow  out  1  sticky: a frame started while the FIFO was empty.
frameStart  out  1  one-clk pulse when a frame is loaded.
mclk  out  1  codec master clock.
bclk  out  1  bit clock.
wclk  out  1  word select; 0 = left, 1 = right.
sdout  out  1  serial data to the codec.

Behaviour:
- Reset (reset==0 on a clk edge):
  - FIFO empty; all counters 0.
  - mclk, bclk, wclk, sdout, sampleReady, underflow and frameStart all 0.
  - After reset is released, sampleReady = !full.
- mclk:
  - Free-running whenever out of reset, independent of enable.
  - Low for the first MCLK_DIV/2 cycles of each period, high for the rest.
- Handshake:
  - A pair is pushed when sampleValid && sampleReady.
  - sampleReady is derived from the registered full flag. A pop in the same cycle does not make a full FIFO accept a push.
  - Push and pop on a non-full, non-empty FIFO in the same cycle both take effect.
- Serialiser counters (advance only while enable==1):
  - bclkCount runs 0..BCLK_DIV-1 and wraps.
  - bclk = 1 when bclkCount >= BCLK_DIV/2.
  - A "falling event" is bclkCount wrapping to 0. bitIndex (0..63) advances on each falling event, wrapping 63 -> 0.
- Frame load:
  - On the falling event where bitIndex becomes 0, and on the first cycle after enable rises, a frame is loaded and frameStart pulses.
  - FIFO non-empty: pop one pair into a 64-bit shift register as {left slot, right slot}.
  - Each 32-bit slot holds the sample MSB-first in its top SAMPLE_WIDTH bits, zero-padded below.
  - FIFO empty: load all zeros and set underflow. If underflowClear is asserted in the same cycle, set wins.
- sdout and wclk:
  - sdout = bit (63 - bitIndex) of the shift register. It changes only on falling events, so it is stable across the bclk rising edge.
  - wclk = 1 when ((bitIndex+1) mod 64) >= 32. wclk therefore leads the slot MSB by one bclk, per I2S.
- Latency: a pair pushed into an empty FIFO appears at the next frame boundary. Its left MSB is on sdout 0..1023 clk after the push (defaults).
- enable falling, including mid-frame:
  - On the next clk, bclk, wclk and sdout go to 0; bclkCount and bitIndex go to 0.
  - The current frame is discarded; FIFO contents are kept.
- enable rising: bclk starts in its low phase, bitIndex = 0, and a frame is loaded on the first cycle.
- Reset mid-frame: everything returns to the reset values on the same edge.
- All outputs are registered, with no combinational path from inputs to the pins.

Decomposition:
- Package i2s_pkg holds:
  - SLOT_BITS = 32 and FRAME_BITS = 64.
  - The stereo_sample_t struct {left, right}, parameterised by SAMPLE_WIDTH via a localparam in the instantiating module.
- One sub-module, i2s_sample_fifo: a synchronous FIFO of FIFO_DEPTH entries with push/pop/full/empty and the same reset.

Test Plan:
- Reset: hold reset=0 for 5 clk with enable=1 -> all outputs 0; after release, sampleReady=1 and mclk period is 4 clk.
- Single frame: push L=16'hA5F0, R=16'h0001, then enable=1 -> sdout carries A5F0 MSB-first in left bits 0..15, zeros in bits 16..31, and 0001 in right bits 32..47.
  - bclk period is 16 clk; wclk rises at bitIndex 31 and falls at 63; frameStart pulses once per 1024 clk.
- Backpressure: push 3 pairs back-to-back with enable=0 -> first two accepted; sampleReady=0 on the third until a frame pop frees space.
- Underflow: enable with an empty FIFO -> all-zero frame and underflow=1; pulse underflowClear -> 0; a second empty frame sets it to 1 again.
- Mid-frame disable: drop enable at bitIndex 20 -> bclk, wclk, sdout = 0 next clk; re-enable -> new frame from the FIFO head, with the old frame not resumed.
- Full-FIFO push/pop collision: FIFO full with a push offered on the pop cycle -> push is accepted the following cycle, and order is preserved.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmitter slice.
package i2s_pkg;

    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = 64;

    // Samples are stored already slot-aligned (MSB at bit 31, zero-padded below).
    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } stereo_sample_t;

    typedef enum logic {
        SER_IDLE,
        SER_RUN
    } ser_state_t;

    function automatic logic [SLOT_BITS-1:0] slot_align(input logic [SLOT_BITS-1:0] sample,
                                                        input int unsigned          pad);
        return sample << pad;
    endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-pair valid/ready handshake between the sample source and the transmitter.
interface i2s_transmitter_if #(
    parameter int unsigned SAMPLE_WIDTH = 16
);
    logic                    sampleValid;
    logic                    sampleReady;
    logic [SAMPLE_WIDTH-1:0] sampleLeft;
    logic [SAMPLE_WIDTH-1:0] sampleRight;

    modport master (output sampleValid, sampleLeft, sampleRight, input sampleReady);
    modport slave  (input sampleValid, sampleLeft, sampleRight, output sampleReady);
endinterface

// File: rtl/i2s_sample_fifo.sv
// Synchronous stereo-pair FIFO; ready is a registered copy of !full that is held low in reset.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_push,
    input  stereo_sample_t i_pushData,
    input  logic           i_pop,
    output stereo_sample_t o_head,
    output logic           o_empty,
    output logic           o_ready
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    stereo_sample_t r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [CW-1:0]  r_count;
    logic           r_full;
    logic           r_empty;
    logic           r_ready;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_countNext;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && !r_empty;
    assign o_head  = r_mem[r_rdPtr];
    assign o_empty = r_empty;
    assign o_ready = r_ready;

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + CW'(1);
            2'b01:   w_countNext = r_count - CW'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= ptr_inc(r_wrPtr);
            if (w_pop)  r_rdPtr <= ptr_inc(r_rdPtr);
            r_count <= w_countNext;
            r_full  <= (w_countNext == CW'(FIFO_DEPTH));
            r_empty <= (w_countNext == '0);
            r_ready <= (w_countNext != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_pushData;
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Stereo I2S (Philips) transmitter: buffered sample pairs serialised as 64-bclk frames,
// plus a free-running codec master clock.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned MCLK_DIV     = 4,
    parameter int unsigned BCLK_DIV     = 16,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    i2s_transmitter_if.slave sample_if,
    input  logic             underflowClear,
    output logic             underflow,
    output logic             frameStart,
    output logic             mclk,
    output logic             bclk,
    output logic             wclk,
    output logic             sdout
);
    localparam int unsigned MCW = $clog2(MCLK_DIV);
    localparam int unsigned BCW = $clog2(BCLK_DIV);
    localparam int unsigned BIW = $clog2(FRAME_BITS);
    localparam int unsigned PAD = SLOT_BITS - SAMPLE_WIDTH;

    logic [MCW-1:0]        r_mclkCount;
    logic                  r_mclk;
    ser_state_t            r_state;
    logic [BCW-1:0]        r_bclkCount;
    logic [BIW-1:0]        r_bitIndex;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_bclk;
    logic                  r_wclk;
    logic                  r_sdout;
    logic                  r_frameStart;
    logic                  r_underflow;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_ready;
    logic                  w_empty;
    stereo_sample_t        w_pushData;
    stereo_sample_t        w_head;
    logic [FRAME_BITS-1:0] w_frame;
    logic [MCW-1:0]        w_mclkNext;
    logic                  w_bclkWrap;
    logic [BCW-1:0]        w_bclkNext;
    logic [BIW-1:0]        w_bitNext;
    logic [BIW-1:0]        w_wsIndex;
    logic                  w_load;

    assign w_pushData.left  = slot_align(SLOT_BITS'(sample_if.sampleLeft), PAD);
    assign w_pushData.right = slot_align(SLOT_BITS'(sample_if.sampleRight), PAD);
    assign w_push           = sample_if.sampleValid && w_ready;
    assign sample_if.sampleReady = w_ready;

    i2s_sample_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_ready    (w_ready)
    );

    assign w_mclkNext = (r_mclkCount == MCW'(MCLK_DIV - 1)) ? '0 : r_mclkCount + MCW'(1);
    assign w_bclkWrap = (r_bclkCount == BCW'(BCLK_DIV - 1));
    assign w_bclkNext = w_bclkWrap ? '0 : r_bclkCount + BCW'(1);
    assign w_bitNext  = r_bitIndex + BIW'(1);
    // wclk reflects the bit after the one being entered, so it leads each slot by one bclk
    assign w_wsIndex  = r_bitIndex + BIW'(2);
    assign w_load     = enable && ((r_state == SER_IDLE) ||
                                   (w_bclkWrap && r_bitIndex == BIW'(FRAME_BITS - 1)));
    assign w_pop      = w_load && !w_empty;
    assign w_frame    = w_empty ? '0 : w_head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mclkCount <= '0;
            r_mclk      <= 1'b0;
        end else begin
            r_mclkCount <= w_mclkNext;
            r_mclk      <= (w_mclkNext >= MCW'(MCLK_DIV / 2));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= SER_IDLE;
            r_bclkCount  <= '0;
            r_bitIndex   <= '0;
            r_shift      <= '0;
            r_bclk       <= 1'b0;
            r_wclk       <= 1'b0;
            r_sdout      <= 1'b0;
            r_frameStart <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_frameStart <= w_load;
            if (w_load && w_empty)
                r_underflow <= 1'b1;
            else if (underflowClear)
                r_underflow <= 1'b0;

            if (!enable) begin
                r_state     <= SER_IDLE;
                r_bclkCount <= '0;
                r_bitIndex  <= '0;
                r_bclk      <= 1'b0;
                r_wclk      <= 1'b0;
                r_sdout     <= 1'b0;
            end else if (r_state == SER_IDLE) begin
                // Counters held at 0 on the load cycle so bit 0 gets a full bclk period
                r_state     <= SER_RUN;
                r_bclkCount <= '0;
                r_bitIndex  <= '0;
                r_bclk      <= 1'b0;
                r_wclk      <= 1'b0;
                r_shift     <= w_frame;
                r_sdout     <= w_frame[FRAME_BITS-1];
            end else begin
                r_bclkCount <= w_bclkNext;
                r_bclk      <= (w_bclkNext >= BCW'(BCLK_DIV / 2));
                if (w_bclkWrap) begin
                    r_bitIndex <= w_bitNext;
                    r_wclk     <= w_wsIndex[BIW-1];
                    if (w_load) begin
                        r_shift <= w_frame;
                        r_sdout <= w_frame[FRAME_BITS-1];
                    end else begin
                        r_shift <= r_shift << 1;
                        r_sdout <= r_shift[FRAME_BITS-2];
                    end
                end
            end
        end
    end

    assign mclk       = r_mclk;
    assign bclk       = r_bclk;
    assign wclk       = r_wclk;
    assign sdout      = r_sdout;
    assign frameStart = r_frameStart;
    assign underflow  = r_underflow;

endmodule
